usb_data_buffer: RTL and testbench

- 64-byte circular FIFO between usb_rx/usb_tx on the USB side and the AHB slave on the bus side.
- usb_rx writes received bytes one per strobe and flushes the buffer at packet start. The AHB slave drains received data 1/2/4 bytes per read.
- The reverse path is the same storage: the AHB slave writes 1/2/4 bytes and usb_tx pops one byte per request.
- buffer_occupancy feeds back to usb_rx and to the AHB status registers.

---
 rtl/usb_data_buffer.sv | 104 ++++++++++
 tb/tb_usb_data_buffer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/usb_data_buffer.sv
// rtl/usb_data_buffer.sv - 64-byte circular byte FIFO shared by usb_rx/usb_tx and the AHB slave
// Optional build macro: USB_BUF_STICKY_ERR_EN (sticky overflow/underflow flags).
module usb_data_buffer #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        store_rx_packet_data,
  input  logic [7:0]  rx_packet_data,
  input  logic        flush,
  input  logic        clear,
  input  logic        store_tx_data,
  input  logic [31:0] tx_data,
  input  logic [1:0]  tx_data_size,
  input  logic        get_rx_data,
  input  logic [1:0]  rx_data_size,
  output logic [31:0] rx_data,
  input  logic        get_tx_packet_data,
  output logic [7:0]  tx_packet_data,
  output logic [6:0]  buffer_occupancy,
  output logic        overflow_err,
  output logic        underflow_err
);

  localparam logic [7:0] DEPTH_B = 8'(DEPTH);

  // Size code 3 is reserved and behaves as a 4-byte transfer.
  function automatic logic [2:0] size_bytes(input logic [1:0] s);
    case (s)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [6:0]        count;

  logic        empty_req;
  logic        wr_req;
  logic        rd_req;
  logic        wr_ok;
  logic        rd_ok;
  logic [2:0]  n_w;
  logic [2:0]  n_r;
  logic [2:0]  n_rx;
  logic [31:0] wr_bytes;

  // RX write beats AHB write; AHB read beats usb_tx pop.
  always_comb begin
    empty_req = clear | flush;
    wr_req    = store_rx_packet_data | store_tx_data;
    n_w       = store_rx_packet_data ? 3'd1 : size_bytes(tx_data_size);
    wr_bytes  = store_rx_packet_data ? {24'd0, rx_packet_data} : tx_data;
    rd_req    = get_rx_data | get_tx_packet_data;
    n_r       = get_rx_data ? size_bytes(rx_data_size) : 3'd1;
    wr_ok     = wr_req && (({1'b0, count} + {5'd0, n_w}) <= DEPTH_B);
    rd_ok     = rd_req && ({1'b0, count} >= {5'd0, n_r});
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !empty_req && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (3'(i) < n_w) mem[wr_ptr + ADDR_W'(i)] <= wr_bytes[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || empty_req) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + ADDR_W'(n_w);
      if (rd_ok) rd_ptr <= rd_ptr + ADDR_W'(n_r);
      count <= count + (wr_ok ? {4'd0, n_w} : 7'd0) - (rd_ok ? {4'd0, n_r} : 7'd0);
`ifdef USB_BUF_STICKY_ERR_EN
      overflow_err  <= overflow_err  | (wr_req & ~wr_ok);
      underflow_err <= underflow_err | (rd_req & ~rd_ok);
`else
      overflow_err  <= wr_req & ~wr_ok;
      underflow_err <= rd_req & ~rd_ok;
`endif
    end
  end

  // Show-ahead read data straight from storage at the current head.
  always_comb begin
    n_rx    = size_bytes(rx_data_size);
    rx_data = '0;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < n_rx) rx_data[8*i +: 8] = mem[rd_ptr + ADDR_W'(i)];
    end
    tx_packet_data   = mem[rd_ptr];
    buffer_occupancy = count;
  end

endmodule

// File: tb/tb_usb_data_buffer.sv
// tb/tb_usb_data_buffer.sv - directed plus randomized bench for usb_data_buffer against a byte-queue model
module tb_usb_data_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        store_rx_packet_data = 1'b0;
  logic [7:0]  rx_packet_data = '0;
  logic        flush = 1'b0;
  logic        clear = 1'b0;
  logic        store_tx_data = 1'b0;
  logic [31:0] tx_data = '0;
  logic [1:0]  tx_data_size = '0;
  logic        get_rx_data = 1'b0;
  logic [1:0]  rx_data_size = '0;
  logic [31:0] rx_data;
  logic        get_tx_packet_data = 1'b0;
  logic [7:0]  tx_packet_data;
  logic [6:0]  buffer_occupancy;
  logic        overflow_err;
  logic        underflow_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] q[$];
  bit exp_ovf = 1'b0;
  bit exp_udf = 1'b0;

  always #5 clk = ~clk;

  usb_data_buffer dut (
    .clk(clk), .rst(rst),
    .store_rx_packet_data(store_rx_packet_data), .rx_packet_data(rx_packet_data),
    .flush(flush), .clear(clear),
    .store_tx_data(store_tx_data), .tx_data(tx_data), .tx_data_size(tx_data_size),
    .get_rx_data(get_rx_data), .rx_data_size(rx_data_size), .rx_data(rx_data),
    .get_tx_packet_data(get_tx_packet_data), .tx_packet_data(tx_packet_data),
    .buffer_occupancy(buffer_occupancy),
    .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  // One clock: check show-ahead outputs, advance the model, check registered outputs.
  task automatic step();
    int nw, nr, cnt;
    bit wreq, rreq, wok, rok;
    logic [31:0] exp_rx, wsrc;
    #1;
    nr = nbytes(rx_data_size);
    if (q.size() >= nr) begin
      exp_rx = '0;
      for (int i = 0; i < nr; i++) exp_rx[8*i +: 8] = q[i];
      check("rx_data", rx_data, exp_rx);
    end
    if (q.size() > 0) check("tx_packet_data", {24'd0, tx_packet_data}, {24'd0, q[0]});
    if (rst || clear || flush) begin
      q.delete();
      exp_ovf = 1'b0;
      exp_udf = 1'b0;
    end else begin
      wreq = store_rx_packet_data || store_tx_data;
      nw   = store_rx_packet_data ? 1 : nbytes(tx_data_size);
      wsrc = store_rx_packet_data ? {24'd0, rx_packet_data} : tx_data;
      rreq = get_rx_data || get_tx_packet_data;
      nr   = get_rx_data ? nbytes(rx_data_size) : 1;
      cnt  = q.size();
      wok  = wreq && (cnt + nw <= 64);
      rok  = rreq && (cnt >= nr);
`ifdef USB_BUF_STICKY_ERR_EN
      exp_ovf = exp_ovf || (wreq && !wok);
      exp_udf = exp_udf || (rreq && !rok);
`else
      exp_ovf = wreq && !wok;
      exp_udf = rreq && !rok;
`endif
      if (rok) repeat (nr) void'(q.pop_front());
      if (wok) for (int i = 0; i < nw; i++) q.push_back(wsrc[8*i +: 8]);
    end
    @(posedge clk);
    #1;
    check("occupancy", {25'd0, buffer_occupancy}, 32'(q.size()));
    check("overflow_err", {31'd0, overflow_err}, {31'd0, exp_ovf});
    check("underflow_err", {31'd0, underflow_err}, {31'd0, exp_udf});
    rst = 0; store_rx_packet_data = 0; store_tx_data = 0; flush = 0; clear = 0;
    get_rx_data = 0; get_tx_packet_data = 0;
  endtask

  task automatic rx_wr(input logic [7:0] b);
    store_rx_packet_data = 1; rx_packet_data = b; step();
  endtask

  task automatic ahb_wr(input logic [31:0] d, input logic [1:0] s);
    store_tx_data = 1; tx_data = d; tx_data_size = s; step();
  endtask

  task automatic ahb_rd(input logic [1:0] s);
    get_rx_data = 1; rx_data_size = s; step();
  endtask

  task automatic tx_pop();
    get_tx_packet_data = 1; step();
  endtask

  task automatic do_clear();
    clear = 1; step();
  endtask

  task automatic fill_full();
    for (int k = 0; k < 16; k++) ahb_wr(32'hA0B0C0D0 + 32'(k), 2'd2);
  endtask

  initial begin
    #1;
    rst = 1; step();
    check("reset_occupancy", {25'd0, buffer_occupancy}, 32'd0);

    rx_wr(8'h2D); rx_wr(8'h11); rx_wr(8'h22); rx_wr(8'h33); rx_wr(8'h44);
    check("plan_occ5", {25'd0, buffer_occupancy}, 32'd5);
    get_rx_data = 1; rx_data_size = 2'd1; #1;
    check("plan_rx_2b", rx_data, 32'h0000112D);
    step();
    check("plan_occ3", {25'd0, buffer_occupancy}, 32'd3);

    do_clear();
    fill_full();
    check("plan_full", {25'd0, buffer_occupancy}, 32'd64);
    rx_wr(8'h55);
    check("plan_ovf_pulse", {31'd0, overflow_err}, 32'd1);
    step();

    do_clear();
    for (int k = 0; k < 15; k++) ahb_wr(32'h10203040 + 32'(k), 2'd2);
    ahb_wr(32'h0000BEEF, 2'd1);
    for (int k = 0; k < 15; k++) ahb_rd(2'd2);
    ahb_wr(32'h04030201, 2'd2);
    tx_pop(); tx_pop();
    for (int k = 1; k <= 4; k++) begin
      get_tx_packet_data = 1; #1;
      check("plan_wrap_byte", {24'd0, tx_packet_data}, 32'(k));
      step();
    end

    do_clear();
    rx_wr(8'hC1); rx_wr(8'hC2); rx_wr(8'hC3);
    ahb_rd(2'd2);
    check("plan_udf", {31'd0, underflow_err}, 32'd1);
    get_tx_packet_data = 1; #1;
    check("plan_head_after_udf", {24'd0, tx_packet_data}, 32'h000000C1);
    step();
    check("plan_occ2", {25'd0, buffer_occupancy}, 32'd2);

    do_clear();
    fill_full();
    rx_wr(8'h77);
    for (int k = 0; k < 27; k++) ahb_rd(2'd1);
    flush = 1; store_rx_packet_data = 1; rx_packet_data = 8'h99; step();
    check("plan_flush_occ", {25'd0, buffer_occupancy}, 32'd0);
    check("plan_flush_err", {31'd0, overflow_err}, 32'd0);

    fill_full();
    store_rx_packet_data = 1; rx_packet_data = 8'h66; get_tx_packet_data = 1; step();
    check("plan_full_pop_occ", {25'd0, buffer_occupancy}, 32'd63);
    check("plan_full_pop_ovf", {31'd0, overflow_err}, 32'd1);

    for (int ph = 0; ph < 15; ph++) begin
      int wp, rp;
      wp = $urandom_range(10, 90);
      rp = $urandom_range(10, 90);
      for (int c = 0; c < 200; c++) begin
        store_rx_packet_data = ($urandom_range(0, 99) < wp);
        rx_packet_data       = 8'($urandom);
        store_tx_data        = ($urandom_range(0, 99) < wp);
        tx_data              = $urandom;
        tx_data_size         = 2'($urandom);
        get_rx_data          = ($urandom_range(0, 99) < rp);
        rx_data_size         = 2'($urandom);
        get_tx_packet_data   = ($urandom_range(0, 99) < rp);
        clear                = ($urandom_range(0, 299) == 0);
        flush                = ($urandom_range(0, 299) == 0);
        rst                  = ($urandom_range(0, 599) == 0);
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

endmodule
